// File: rtl/rfnoc_conv2bto32b_pack_pkg.sv
// rtl/rfnoc_conv2bto32b_pack_pkg.sv - shared QPSK packing constants and slot placement helper
package rfnoc_conv2bto32b_pack_pkg;

    localparam int DEF_ITEM_W = 32;
    localparam int DEF_SYM_W  = 2;
    localparam int DEF_CHDR_W = 64;
    localparam int CTX_USER_W = 4;

    // Bit offset of symbol slot 'slot' inside a word of 'spw' symbols.
    // msb_first puts slot 0 at the top of the word, otherwise at the bottom.
    function automatic int slot_lsb(input int slot, input int spw, input int sym_w,
                                    input bit msb_first);
        return msb_first ? (spw - 1 - slot) * sym_w : slot * sym_w;
    endfunction

endpackage

// File: rtl/rfnoc_conv2bto32b_pack_axis_pipe_reg.sv
// rtl/rfnoc_conv2bto32b_pack_axis_pipe_reg.sv - generic one-deep registered AXIS stage
module rfnoc_conv2bto32b_pack_axis_pipe_reg #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_s_tdata,
    input  logic         i_s_tvalid,
    output logic         o_s_tready,
    output logic [W-1:0] o_m_tdata,
    output logic         o_m_tvalid,
    input  logic         i_m_tready
);

    logic [W-1:0] r_data;
    logic         r_valid;

    assign o_s_tready = !r_valid | i_m_tready;
    assign o_m_tdata  = r_data;
    assign o_m_tvalid = r_valid;

    // Capture a beat whenever the register is empty or being drained this cycle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_s_tvalid && o_s_tready) begin
            r_data  <= i_s_tdata;
            r_valid <= 1'b1;
        end else if (i_m_tready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rfnoc_conv2bto32b_pack.sv
// rtl/rfnoc_conv2bto32b_pack.sv - packs 2-bit QPSK symbols into 32-bit words with zero-padded packet tail
module rfnoc_conv2bto32b_pack
    import rfnoc_conv2bto32b_pack_pkg::*;
#(
    parameter int ITEM_W    = DEF_ITEM_W,
    parameter int SYM_W     = DEF_SYM_W,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CHDR_W    = DEF_CHDR_W
) (
    input  logic                  axis_data_clk,
    input  logic                  axis_data_rst,
    input  logic [ITEM_W-1:0]     s_payload_tdata,
    input  logic                  s_payload_tlast,
    input  logic                  s_payload_tvalid,
    output logic                  s_payload_tready,
    input  logic [CHDR_W-1:0]     s_context_tdata,
    input  logic [CTX_USER_W-1:0] s_context_tuser,
    input  logic                  s_context_tlast,
    input  logic                  s_context_tvalid,
    output logic                  s_context_tready,
    output logic [ITEM_W-1:0]     m_payload_tdata,
    output logic                  m_payload_tkeep,
    output logic                  m_payload_tlast,
    output logic                  m_payload_tvalid,
    input  logic                  m_payload_tready,
    output logic [CHDR_W-1:0]     m_context_tdata,
    output logic [CTX_USER_W-1:0] m_context_tuser,
    output logic                  m_context_tlast,
    output logic                  m_context_tvalid,
    input  logic                  m_context_tready,
    output logic [31:0]           stat_pkt_count,
    output logic [31:0]           stat_pad_syms
);

    localparam int SPW   = ITEM_W / SYM_W;
    localparam int CNT_W = $clog2(SPW);
    localparam int CTX_W = CHDR_W + CTX_USER_W + 1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(SPW - 1);
    localparam logic [ITEM_W-1:0] SYM_MASK = {{(ITEM_W - SYM_W){1'b0}}, {SYM_W{1'b1}}};

    logic [CNT_W-1:0]  r_sym_cnt;
    logic [ITEM_W-1:0] r_acc;
    logic [ITEM_W-1:0] r_out_data;
    logic              r_out_last;
    logic              r_out_valid;
    logic [31:0]       r_stat_pkt;
    logic [31:0]       r_stat_pad;

    logic              w_accept;
    logic              w_full;
    logic              w_emit;
    logic [ITEM_W-1:0] w_word;
    logic [CTX_W-1:0]  w_ctx_in;
    logic [CTX_W-1:0]  w_ctx_out;

    assign s_payload_tready = !r_out_valid | m_payload_tready;
    assign w_accept         = s_payload_tvalid & s_payload_tready;
    assign w_full           = (r_sym_cnt == CNT_MAX);
    assign w_emit           = w_accept & (s_payload_tlast | w_full);

    assign m_payload_tdata  = r_out_data;
    assign m_payload_tkeep  = 1'b1;
    assign m_payload_tlast  = r_out_last;
    assign m_payload_tvalid = r_out_valid;
    assign stat_pkt_count   = r_stat_pkt;
    assign stat_pad_syms    = r_stat_pad;

    // Merge the incoming symbol into its slot; unfilled slots are already zero, which forms the pad
    always_comb begin
        w_word = r_acc | ((s_payload_tdata & SYM_MASK)
                          << slot_lsb(int'(r_sym_cnt), SPW, SYM_W, MSB_FIRST));
    end

    // Symbol slot counter and partial-word accumulator, cleared each time a word is handed off
    always_ff @(posedge axis_data_clk or posedge axis_data_rst) begin
        if (axis_data_rst) begin
            r_sym_cnt <= '0;
            r_acc     <= '0;
        end else if (w_accept) begin
            if (w_emit) begin
                r_sym_cnt <= '0;
                r_acc     <= '0;
            end else begin
                r_sym_cnt <= r_sym_cnt + CNT_W'(1);
                r_acc     <= w_word;
            end
        end
    end

    // Output holding register; a new word only loads when the previous one has been taken
    always_ff @(posedge axis_data_clk or posedge axis_data_rst) begin
        if (axis_data_rst) begin
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_emit) begin
            r_out_data  <= w_word;
            r_out_last  <= s_payload_tlast;
            r_out_valid <= 1'b1;
        end else if (m_payload_tready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Packet and pad-symbol statistics, counted when the packet's last symbol is accepted
    always_ff @(posedge axis_data_clk or posedge axis_data_rst) begin
        if (axis_data_rst) begin
            r_stat_pkt <= '0;
            r_stat_pad <= '0;
        end else if (w_accept && s_payload_tlast) begin
            r_stat_pkt <= r_stat_pkt + 32'd1;
            r_stat_pad <= r_stat_pad + 32'(CNT_MAX - r_sym_cnt);
        end
    end

    assign w_ctx_in = {s_context_tuser, s_context_tlast, s_context_tdata};

    rfnoc_conv2bto32b_pack_axis_pipe_reg #(
        .W (CTX_W)
    ) u_ctx_reg (
        .i_clk      (axis_data_clk),
        .i_rst      (axis_data_rst),
        .i_s_tdata  (w_ctx_in),
        .i_s_tvalid (s_context_tvalid),
        .o_s_tready (s_context_tready),
        .o_m_tdata  (w_ctx_out),
        .o_m_tvalid (m_context_tvalid),
        .i_m_tready (m_context_tready)
    );

    assign m_context_tuser = w_ctx_out[CTX_W-1 -: CTX_USER_W];
    assign m_context_tlast = w_ctx_out[CHDR_W];
    assign m_context_tdata = w_ctx_out[CHDR_W-1:0];

endmodule
